// File: rtl/axis_sample_packetizer.sv
// axis_sample_packetizer: buffers a free-running sample stream in a small
// first-word-fall-through FIFO and emits fixed-length AXI4-Stream packets.
// Ports: clk_i/rstn_i (async active-low); smp_dat_i/smp_vld_i sample input;
//   cfg_len_i beats per packet; ctl_start_i/ctl_stop_i control pulses;
//   m_t* AXI4-Stream master; sts_busy_o, sts_ovf_o, sts_pkt_cnt_o status.
// Optional: define AXIS_PKT_CNT_EN to build the completed-packet counter;
//   otherwise sts_pkt_cnt_o is tied to 0.
module axis_sample_packetizer #(
    parameter int DW = 16,
    parameter int FD = 16,
    parameter int LW = 16
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic [DW-1:0]   smp_dat_i,
    input  logic            smp_vld_i,
    input  logic [LW-1:0]   cfg_len_i,
    input  logic            ctl_start_i,
    input  logic            ctl_stop_i,
    output logic [DW-1:0]   m_tdata_o,
    output logic [DW/8-1:0] m_tkeep_o,
    output logic            m_tlast_o,
    output logic            m_tvalid_o,
    input  logic            m_tready_i,
    output logic            sts_busy_o,
    output logic            sts_ovf_o,
    output logic [31:0]     sts_pkt_cnt_o
);

    localparam int AW = $clog2(FD);
    localparam int KW = DW / 8;
    localparam logic [AW+1:0] FD_OCC = (AW + 2)'(FD);
    localparam logic [LW-1:0] ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        PAD,
        DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [DW-1:0] mem [FD];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]   fifo_cnt;
    logic [AW+1:0] occ;
    logic          fifo_empty;

    logic [LW-1:0] len_q, beat_q;
    logic          ovf_q, busy_q;

    logic [DW-1:0] tdata_q;
    logic [KW-1:0] tkeep_q;
    logic          tvalid_q;

    logic hs, reload, last_beat, data_phase;
    logic fifo_rd, fifo_wr, wr_req, pad_load, start_acc;

    assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (fifo_cnt == '0);
    // The output register counts toward the FD-word capacity.
    assign occ        = {1'b0, fifo_cnt} + {{(AW + 1){1'b0}}, tvalid_q};

    assign hs         = tvalid_q & m_tready_i;
    assign reload     = ~tvalid_q | m_tready_i;
    assign last_beat  = (beat_q == len_q - ONE);
    assign data_phase = (state_q == STREAM) || (state_q == DRAIN);
    assign start_acc  = (state_q == IDLE) & ctl_start_i & ~ctl_stop_i;

    assign wr_req   = (state_q == STREAM) & smp_vld_i & ~ctl_stop_i;
    // A handshake frees a slot in the same cycle, so a write at full succeeds.
    assign fifo_wr  = wr_req & ((occ != FD_OCC) | hs);
    assign fifo_rd  = reload & data_phase & ~fifo_empty;
    // Stop issuing pad beats once the final (TLAST) beat is on the bus.
    assign pad_load = (state_q == PAD) & reload & ~(tvalid_q & last_beat);

    always_ff @(posedge clk_i) begin
        if (fifo_wr) begin
            mem[wr_ptr_q[AW-1:0]] <= smp_dat_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (fifo_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (fifo_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
        end else if (reload) begin
            if (fifo_rd) begin
                tvalid_q <= 1'b1;
                tdata_q  <= mem[rd_ptr_q[AW-1:0]];
                tkeep_q  <= '1;
            end else if (pad_load) begin
                tvalid_q <= 1'b1;
                tdata_q  <= '0;
                tkeep_q  <= '0;
            end else begin
                tvalid_q <= 1'b0;
                tdata_q  <= '0;
                tkeep_q  <= '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            len_q  <= ONE;
            beat_q <= '0;
            ovf_q  <= 1'b0;
        end else if (start_acc) begin
            len_q  <= (cfg_len_i == '0) ? ONE : cfg_len_i;
            beat_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (hs) beat_q <= last_beat ? '0 : beat_q + ONE;
            if (wr_req && !fifo_wr) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_acc) state_d = STREAM;
            end
            STREAM: begin
                if (ctl_stop_i) state_d = DRAIN;
            end
            DRAIN: begin
                // Leave once the last buffered beat has left the output register;
                // the beat count after that handshake selects IDLE or PAD.
                if (fifo_empty && (!tvalid_q || hs)) begin
                    if (hs ? last_beat : (beat_q == '0)) state_d = IDLE;
                    else                                  state_d = PAD;
                end
            end
            PAD: begin
                if (hs && last_beat) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef AXIS_PKT_CNT_EN
    logic [31:0] pkt_cnt_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pkt_cnt_q <= '0;
        end else if (hs && last_beat) begin
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
        end
    end

    assign sts_pkt_cnt_o = pkt_cnt_q;
`else
    assign sts_pkt_cnt_o = '0;
`endif

    assign m_tdata_o  = tdata_q;
    assign m_tkeep_o  = tkeep_q;
    assign m_tvalid_o = tvalid_q;
    assign m_tlast_o  = tvalid_q & last_beat;
    assign sts_busy_o = busy_q;
    assign sts_ovf_o  = ovf_q;

endmodule

// File: tb/tb_axis_sample_packetizer.sv
// Bench for axis_sample_packetizer: a queue model of the expected beat stream
// checked on every handshake, plus directed literal expectations.
module tb_axis_sample_packetizer;

    localparam int DW = 16;
    localparam int FD = 16;
    localparam int LW = 16;
    localparam int KW = DW / 8;

    logic            clk = 1'b0;
    logic            rstn_i;
    logic [DW-1:0]   smp_dat_i;
    logic            smp_vld_i;
    logic [LW-1:0]   cfg_len_i;
    logic            ctl_start_i;
    logic            ctl_stop_i;
    logic [DW-1:0]   m_tdata_o;
    logic [KW-1:0]   m_tkeep_o;
    logic            m_tlast_o;
    logic            m_tvalid_o;
    logic            m_tready_i;
    logic            sts_busy_o;
    logic            sts_ovf_o;
    logic [31:0]     sts_pkt_cnt_o;

    always #5 clk = ~clk;

    axis_sample_packetizer #(.DW(DW), .FD(FD), .LW(LW)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn_i),
        .smp_dat_i    (smp_dat_i),
        .smp_vld_i    (smp_vld_i),
        .cfg_len_i    (cfg_len_i),
        .ctl_start_i  (ctl_start_i),
        .ctl_stop_i   (ctl_stop_i),
        .m_tdata_o    (m_tdata_o),
        .m_tkeep_o    (m_tkeep_o),
        .m_tlast_o    (m_tlast_o),
        .m_tvalid_o   (m_tvalid_o),
        .m_tready_i   (m_tready_i),
        .sts_busy_o   (sts_busy_o),
        .sts_ovf_o    (sts_ovf_o),
        .sts_pkt_cnt_o(sts_pkt_cnt_o)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

`ifdef AXIS_PKT_CNT_EN
    localparam bit PKT_EN = 1'b1;
`else
    localparam bit PKT_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int first_valid_cyc = -1;

    beat_t exp_q[$];
    beat_t log_q[$];

    bit          m_run = 0;
    int          m_len = 1;
    int          m_idx = 0;
    int          m_occ = 0;
    logic        m_ovf = 0;
    logic [31:0] m_pkt = 0;
    bit          stall_prev = 0;
    beat_t       prev_b;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                 input logic l);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        return b;
    endfunction

    function automatic logic [31:0] exp_pkt(input logic [31:0] n);
        return PKT_EN ? n : 32'd0;
    endfunction

    function automatic beat_t log_at(input int i);
        if (i < log_q.size()) return log_q[i];
        return mk('x, 'x, 1'bx);
    endfunction

    // Packet model: a run's beats are its accepted samples, padded with
    // zero/keep-0 beats up to a multiple of the latched length.
    task automatic push_beat(input logic [DW-1:0] d, input logic [KW-1:0] k);
        exp_q.push_back(mk(d, k, (m_idx % m_len) == m_len - 1));
        m_idx++;
    endtask

    always @(negedge clk) begin
        beat_t b, cur;
        if (!rstn_i) begin
            exp_q.delete();
            m_run = 0;
            m_occ = 0;
            m_ovf = 0;
            m_pkt = 0;
            stall_prev = 0;
        end else begin
            cur = mk(m_tdata_o, m_tkeep_o, m_tlast_o);
            check("ovf_flag", 64'(sts_ovf_o), 64'(m_ovf));
            check("pkt_cnt", 64'(sts_pkt_cnt_o), 64'(exp_pkt(m_pkt)));
            if (stall_prev) begin
                check("stall_valid", 64'(m_tvalid_o), 64'd1);
                check("stall_hold", 64'(cur), 64'(prev_b));
            end
            stall_prev = m_tvalid_o && !m_tready_i;
            prev_b = cur;
            if (m_tvalid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_tvalid_o && m_tready_i) begin
                log_q.push_back(cur);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: got beat 0x%0h, expected no beat",
                             cur);
                end else begin
                    b = exp_q.pop_front();
                    if (cur !== b) begin
                        n_fail++;
                        $display("FAIL beat: got 0x%0h, expected 0x%0h", cur, b);
                    end
                    if (b.keep != '0) m_occ--;
                    if (b.last) m_pkt++;
                end
            end
            if (m_run) begin
                if (ctl_stop_i) begin
                    m_run = 0;
                    while (m_idx % m_len != 0) push_beat('0, '0);
                end else if (smp_vld_i) begin
                    if (m_occ < FD) begin
                        push_beat(smp_dat_i, '1);
                        m_occ++;
                    end else begin
                        m_ovf = 1;
                    end
                end
            end else if (ctl_start_i && !ctl_stop_i) begin
                m_run = 1;
                m_len = (cfg_len_i == '0) ? 1 : int'(cfg_len_i);
                m_idx = 0;
                m_ovf = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int len);
        cfg_len_i = LW'(len);
        ctl_start_i = 1'b1;
        tick();
        ctl_start_i = 1'b0;
    endtask

    task automatic stop();
        ctl_stop_i = 1'b1;
        tick();
        ctl_stop_i = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d);
        smp_vld_i = 1'b1;
        smp_dat_i = d;
        tick();
        smp_vld_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            if (!sts_busy_o && exp_q.size() == 0) done = 1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL idle_timeout: busy=%0d pending=%0d, expected busy=0 pending=0",
                     sts_busy_o, exp_q.size());
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit pat [4];
        bit hit;
        int n0;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        rstn_i = 1'b0;
        smp_dat_i = '0;
        smp_vld_i = 1'b0;
        cfg_len_i = '0;
        ctl_start_i = 1'b0;
        ctl_stop_i = 1'b0;
        m_tready_i = 1'b1;
        #12;
        check("rst_tvalid", 64'(m_tvalid_o), 64'd0);
        check("rst_tdata", 64'(m_tdata_o), 64'd0);
        check("rst_busy", 64'(sts_busy_o), 64'd0);
        check("rst_pkt", 64'(sts_pkt_cnt_o), 64'd0);
        tick();
        rstn_i = 1'b1;
        tick();

        // Basic: sample with start is dropped, then 1..8 in len-4 packets.
        log_q.delete();
        first_valid_cyc = -1;
        cfg_len_i = 16'd4;
        smp_vld_i = 1'b1;
        smp_dat_i = 16'hDEAD;
        ctl_start_i = 1'b1;
        tick();
        ctl_start_i = 1'b0;
        check("busy_after_start", 64'(sts_busy_o), 64'd1);
        n0 = cyc;
        for (int i = 1; i <= 8; i++) send(DW'(i));
        stop();
        wait_idle(100);
        check("basic_count", 64'(log_q.size()), 64'd8);
        check("basic_b0", 64'(log_at(0)), 64'(mk(16'd1, 2'b11, 1'b0)));
        check("basic_b3", 64'(log_at(3)), 64'(mk(16'd4, 2'b11, 1'b1)));
        check("basic_b7", 64'(log_at(7)), 64'(mk(16'd8, 2'b11, 1'b1)));
        check("basic_latency", 64'(first_valid_cyc - n0), 64'd2);
        check("basic_pkt", 64'(sts_pkt_cnt_o), 64'(exp_pkt(32'd2)));
        check("basic_idle", 64'(sts_busy_o), 64'd0);

        // Backpressure: TREADY pattern 1,0,0,1 over a 4-beat packet.
        log_q.delete();
        start(4);
        for (int i = 0; i < 100; i++) begin
            m_tready_i = pat[i % 4];
            smp_vld_i = (i < 4);
            smp_dat_i = DW'(16'h11 + i);
            ctl_stop_i = (i == 4);
            tick();
            if (i > 4 && !sts_busy_o && exp_q.size() == 0) break;
        end
        smp_vld_i = 1'b0;
        ctl_stop_i = 1'b0;
        m_tready_i = 1'b1;
        wait_idle(20);
        check("bp_count", 64'(log_q.size()), 64'd4);
        check("bp_b1", 64'(log_at(1)), 64'(mk(16'h12, 2'b11, 1'b0)));
        check("bp_b3", 64'(log_at(3)), 64'(mk(16'h14, 2'b11, 1'b1)));

        // Overflow: 20 samples into a stalled 16-word buffer.
        log_q.delete();
        m_tready_i = 1'b0;
        start(16);
        for (int i = 0; i < 20; i++) send(DW'(16'h100 + i));
        check("ovf_set", 64'(sts_ovf_o), 64'd1);
        m_tready_i = 1'b1;
        stop();
        wait_idle(100);
        check("ovf_count", 64'(log_q.size()), 64'd16);
        check("ovf_b0", 64'(log_at(0)), 64'(mk(16'h100, 2'b11, 1'b0)));
        check("ovf_b15", 64'(log_at(15)), 64'(mk(16'h10F, 2'b11, 1'b1)));
        start(4);
        check("ovf_cleared", 64'(sts_ovf_o), 64'd0);
        stop();
        wait_idle(20);

        // Stop with padding: 6 samples in len-4 packets.
        log_q.delete();
        start(4);
        for (int i = 0; i < 6; i++) send(DW'(16'h21 + i));
        stop();
        wait_idle(100);
        check("pad_count", 64'(log_q.size()), 64'd8);
        check("pad_b3", 64'(log_at(3)), 64'(mk(16'h24, 2'b11, 1'b1)));
        check("pad_b5", 64'(log_at(5)), 64'(mk(16'h26, 2'b11, 1'b0)));
        check("pad_b6", 64'(log_at(6)), 64'(mk(16'h0, 2'b00, 1'b0)));
        check("pad_b7", 64'(log_at(7)), 64'(mk(16'h0, 2'b00, 1'b1)));
        check("pad_idle", 64'(sts_busy_o), 64'd0);

        // Zero length behaves as one: every beat carries TLAST.
        log_q.delete();
        start(0);
        for (int i = 0; i < 3; i++) send(DW'(16'h31 + i));
        stop();
        wait_idle(50);
        check("len0_count", 64'(log_q.size()), 64'd3);
        check("len0_b0", 64'(log_at(0)), 64'(mk(16'h31, 2'b11, 1'b1)));
        check("len0_b2", 64'(log_at(2)), 64'(mk(16'h33, 2'b11, 1'b1)));

        // Start and stop together from idle: nothing starts.
        log_q.delete();
        cfg_len_i = 16'd4;
        ctl_start_i = 1'b1;
        ctl_stop_i = 1'b1;
        tick();
        ctl_start_i = 1'b0;
        ctl_stop_i = 1'b0;
        check("ss_busy", 64'(sts_busy_o), 64'd0);
        send(16'h77);
        send(16'h78);
        tick();
        tick();
        check("ss_no_beats", 64'(log_q.size()), 64'd0);

        // Stop on a packet boundary, with cfg_len changed mid-run.
        log_q.delete();
        start(4);
        cfg_len_i = 16'd2;
        for (int i = 0; i < 4; i++) send(DW'(16'h51 + i));
        for (int i = 0; i < 20 && log_q.size() < 4; i++) tick();
        stop();
        wait_idle(10);
        check("bnd_count", 64'(log_q.size()), 64'd4);
        check("bnd_b1", 64'(log_at(1)), 64'(mk(16'h52, 2'b11, 1'b0)));
        check("bnd_b3", 64'(log_at(3)), 64'(mk(16'h54, 2'b11, 1'b1)));

        // Reset asserted while beat 2 is on the bus.
        log_q.delete();
        hit = 0;
        start(4);
        for (int i = 0; i < 20 && !hit; i++) begin
            smp_vld_i = (i < 4);
            smp_dat_i = DW'(16'h61 + i);
            tick();
            if (m_tvalid_o && m_tdata_o == 16'h62) hit = 1;
        end
        smp_vld_i = 1'b0;
        check("rst_beat2_seen", 64'(hit), 64'd1);
        #1;
        rstn_i = 1'b0;
        #1;
        check("arst_tvalid", 64'(m_tvalid_o), 64'd0);
        check("arst_tdata", 64'(m_tdata_o), 64'd0);
        check("arst_tkeep", 64'(m_tkeep_o), 64'd0);
        check("arst_tlast", 64'(m_tlast_o), 64'd0);
        check("arst_busy", 64'(sts_busy_o), 64'd0);
        check("arst_pkt", 64'(sts_pkt_cnt_o), 64'd0);
        tick();
        tick();
        rstn_i = 1'b1;
        tick();
        log_q.delete();
        start(4);
        for (int i = 0; i < 4; i++) send(DW'(16'h71 + i));
        stop();
        wait_idle(50);
        check("post_rst_count", 64'(log_q.size()), 64'd4);
        check("post_rst_b0", 64'(log_at(0)), 64'(mk(16'h71, 2'b11, 1'b0)));
        check("post_rst_b3", 64'(log_at(3)), 64'(mk(16'h74, 2'b11, 1'b1)));
        check("post_rst_pkt", 64'(sts_pkt_cnt_o), 64'(exp_pkt(32'd1)));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
